// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Shares a single dcache request port between LSU pipe 0 (p0) and pipe 1 (p1).
//   One request is granted per cycle. p0 normally wins. p1 gets forced priority
//   after losing STARVE_LIMIT cycles in a row. A grant stalled on dcache_addr_ok
//   stays locked to its owner. An in-order FIFO of issuer IDs steers each
//   dcache_data_ok/rdata back to the port that issued the request.
//
// Ports
//   clk, reset             clock; synchronous active-low reset (0 = reset)
//   pN_req/wr/size/wstrb/addr/wdata/uncached   request from LSU port N
//   pN_addr_ok             request from port N accepted this cycle
//   pN_data_ok, pN_rdata   response for the oldest port-N request
//   dcache_req + fields    muxed request to the dcache
//   dcache_addr_ok         dcache accepted the presented request
//   dcache_data_ok/rdata   in-order response from the dcache
//   outstanding            accepted-but-unreturned request count
//   err_spurious           sticky: response arrived with nothing outstanding
module dcache_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [1:0]  p0_size,
  input  logic [3:0]  p0_wstrb,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_uncached,
  output logic        p0_addr_ok,
  output logic        p0_data_ok,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [1:0]  p1_size,
  input  logic [3:0]  p1_wstrb,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_uncached,
  output logic        p1_addr_ok,
  output logic        p1_data_ok,
  output logic [31:0] p1_rdata,
  output logic        dcache_req,
  output logic        dcache_wr,
  output logic [1:0]  dcache_size,
  output logic [3:0]  dcache_wstrb,
  output logic [31:0] dcache_addr,
  output logic [31:0] dcache_wdata,
  output logic        dcache_uncached,
  input  logic        dcache_addr_ok,
  input  logic        dcache_data_ok,
  input  logic [31:0] dcache_rdata,
  output logic [3:0]  outstanding,
  output logic        err_spurious
);

  localparam int         PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [3:0] MAX_CNT    = 4'(MAX_OUTSTANDING);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]       lock_state_reg, lock_state_next;
  logic             lock_owner_reg, lock_owner_next;
  logic [3:0]       starve_cnt_reg, starve_cnt_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [3:0]       count_reg;
  logic             err_spurious_reg;
  logic             id_fifo_mem [MAX_OUTSTANDING];

  logic [1:0] req_vec;
  logic [1:0] addr_ok_vec;
  logic [1:0] data_ok_vec;
  logic       grant_valid;
  logic       grant_id;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       head_id;

  assign req_vec = {p1_req, p0_req};
  assign full    = (count_reg == MAX_CNT);
  assign empty   = (count_reg == 4'd0);

  // Grant: held owner first, then a starved p1, then fixed p0 > p1 priority.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (lock_state_reg == ST_LOCKED) begin
      grant_valid = 1'b1;
      grant_id    = lock_owner_reg;
    end else if (starve_cnt_reg >= STARVE_LIM && p1_req) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end else if (p0_req) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (p1_req) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // Full is taken from registered occupancy, so a pop in the same cycle
  // does not unmask the request until the following cycle.
  assign dcache_req = reset && grant_valid && req_vec[grant_id] && !full;
  assign push       = dcache_req && dcache_addr_ok;
  assign pop        = reset && dcache_data_ok && !empty;
  assign head_id    = id_fifo_mem[rd_ptr_reg];

  // p0 fields are presented whenever p1 does not hold the grant.
  assign dcache_wr       = (grant_valid && grant_id) ? p1_wr       : p0_wr;
  assign dcache_size     = (grant_valid && grant_id) ? p1_size     : p0_size;
  assign dcache_wstrb    = (grant_valid && grant_id) ? p1_wstrb    : p0_wstrb;
  assign dcache_addr     = (grant_valid && grant_id) ? p1_addr     : p0_addr;
  assign dcache_wdata    = (grant_valid && grant_id) ? p1_wdata    : p0_wdata;
  assign dcache_uncached = (grant_valid && grant_id) ? p1_uncached : p0_uncached;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign addr_ok_vec[gi] = push && (grant_id == 1'(gi));
      assign data_ok_vec[gi] = pop  && (head_id  == 1'(gi));
    end
  endgenerate

  assign p0_addr_ok   = addr_ok_vec[0];
  assign p1_addr_ok   = addr_ok_vec[1];
  assign p0_data_ok   = data_ok_vec[0];
  assign p1_data_ok   = data_ok_vec[1];
  assign p0_rdata     = dcache_rdata;
  assign p1_rdata     = dcache_rdata;
  assign outstanding  = count_reg;
  assign err_spurious = err_spurious_reg;

  // Lock: a presented-but-unaccepted request pins the grant until the dcache
  // takes it or the owner withdraws.
  always_comb begin
    lock_state_next = lock_state_reg;
    lock_owner_next = lock_owner_reg;
    case (lock_state_reg)
      ST_UNLOCKED: begin
        if (dcache_req && !dcache_addr_ok) begin
          lock_state_next = ST_LOCKED;
          lock_owner_next = grant_id;
        end
      end
      default: begin
        if (dcache_addr_ok || !req_vec[lock_owner_reg]) begin
          lock_state_next = ST_UNLOCKED;
        end
      end
    endcase
  end

  always_comb begin
    starve_cnt_next = 4'd0;
    if (p1_req && !addr_ok_vec[1]) begin
      starve_cnt_next = (starve_cnt_reg == 4'd15) ? 4'd15 : starve_cnt_reg + 4'd1;
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_state_reg   <= ST_UNLOCKED;
      lock_owner_reg   <= 1'b0;
      starve_cnt_reg   <= 4'd0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= 4'd0;
      err_spurious_reg <= 1'b0;
    end else begin
      lock_state_reg <= lock_state_next;
      lock_owner_reg <= lock_owner_next;
      starve_cnt_reg <= starve_cnt_next;
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop) count_reg <= count_reg + 4'd1;
      else if (!push && pop) count_reg <= count_reg - 4'd1;
      if (dcache_data_ok && empty) err_spurious_reg <= 1'b1;
    end
  end

  // ID storage needs no reset; only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (push) id_fifo_mem[wr_ptr_reg] <= grant_id;
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;

  localparam int MAXO = 4;
  localparam int LIM  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_wr, p0_uncached, p0_addr_ok, p0_data_ok;
  logic [1:0]  p0_size;
  logic [3:0]  p0_wstrb;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_wr, p1_uncached, p1_addr_ok, p1_data_ok;
  logic [1:0]  p1_size;
  logic [3:0]  p1_wstrb;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        dcache_req, dcache_wr, dcache_uncached;
  logic [1:0]  dcache_size;
  logic [3:0]  dcache_wstrb;
  logic [31:0] dcache_addr, dcache_wdata;
  logic        dcache_addr_ok, dcache_data_ok;
  logic [31:0] dcache_rdata;
  logic [3:0]  outstanding;
  logic        err_spurious;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_size(p0_size), .p0_wstrb(p0_wstrb),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_uncached(p0_uncached),
    .p0_addr_ok(p0_addr_ok), .p0_data_ok(p0_data_ok), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_size(p1_size), .p1_wstrb(p1_wstrb),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_uncached(p1_uncached),
    .p1_addr_ok(p1_addr_ok), .p1_data_ok(p1_data_ok), .p1_rdata(p1_rdata),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_size(dcache_size),
    .dcache_wstrb(dcache_wstrb), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_uncached(dcache_uncached), .dcache_addr_ok(dcache_addr_ok),
    .dcache_data_ok(dcache_data_ok), .dcache_rdata(dcache_rdata),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  typedef struct {
    bit          chk_fields;
    bit          dreq, aok0, aok1, dok0, dok1, err;
    logic [31:0] rdata;
    logic [3:0]  outst;
    logic [71:0] fields;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: queue of issuers awaiting a response, which port (if
  // any) is holding the port, and how many cycles in a row p1 has lost.
  int model_ids[$];
  int held_by   = -1;
  int p1_losses = 0;
  bit model_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the expected DUT view of this cycle is queued.
  task automatic step(input bit rst_n, input bit q0, input bit q1,
                      input bit aok, input bit dok, input logic [31:0] rd);
    exp_t e;
    int   g;
    bit   dreq;
    bit   req [2];
    @(posedge clk);
    #1;
    reset          = rst_n;
    p0_req         = q0;
    p1_req         = q1;
    dcache_addr_ok = aok;
    dcache_data_ok = dok;
    dcache_rdata   = rd;
    p0_wr = 1'($urandom); p0_size = 2'($urandom); p0_wstrb = 4'($urandom);
    p0_addr = $urandom; p0_wdata = $urandom; p0_uncached = 1'($urandom);
    p1_wr = 1'($urandom); p1_size = 2'($urandom); p1_wstrb = 4'($urandom);
    p1_addr = $urandom; p1_wdata = $urandom; p1_uncached = 1'($urandom);

    req[0] = q0;
    req[1] = q1;
    if (held_by >= 0)             g = held_by;
    else if (p1_losses >= LIM && q1) g = 1;
    else if (q0)                  g = 0;
    else if (q1)                  g = 1;
    else                          g = -1;
    dreq = rst_n && (g >= 0) && req[g] && (model_ids.size() < MAXO);

    e.chk_fields = rst_n;
    e.dreq  = dreq;
    e.aok0  = dreq && aok && (g == 0);
    e.aok1  = dreq && aok && (g == 1);
    e.dok0  = rst_n && dok && (model_ids.size() > 0) && (model_ids[0] == 0);
    e.dok1  = rst_n && dok && (model_ids.size() > 0) && (model_ids[0] == 1);
    e.err   = model_err;
    e.outst = 4'(model_ids.size());
    e.rdata = rd;
    e.fields = (g == 1) ? {p1_wr, p1_size, p1_wstrb, p1_addr, p1_wdata, p1_uncached}
                        : {p0_wr, p0_size, p0_wstrb, p0_addr, p0_wdata, p0_uncached};
    exp_q.push_back(e);

    if (!rst_n) begin
      model_ids.delete();
      held_by   = -1;
      p1_losses = 0;
      model_err = 1'b0;
    end else begin
      if (dok) begin
        if (model_ids.size() > 0) void'(model_ids.pop_front());
        else model_err = 1'b1;
      end
      if (dreq && aok) model_ids.push_back(g);
      if (held_by < 0) begin
        if (dreq && !aok) held_by = g;
      end else if (aok || !req[held_by]) begin
        held_by = -1;
      end
      if (q1 && !e.aok1) p1_losses = (p1_losses < 15) ? p1_losses + 1 : 15;
      else               p1_losses = 0;
    end
  endtask

  // Monitor: compares the DUT against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dcache_req",   72'(dcache_req),   72'(e.dreq));
        check("p0_addr_ok",   72'(p0_addr_ok),   72'(e.aok0));
        check("p1_addr_ok",   72'(p1_addr_ok),   72'(e.aok1));
        check("p0_data_ok",   72'(p0_data_ok),   72'(e.dok0));
        check("p1_data_ok",   72'(p1_data_ok),   72'(e.dok1));
        check("outstanding",  72'(outstanding),  72'(e.outst));
        check("err_spurious", 72'(err_spurious), 72'(e.err));
        if (e.dok0) check("p0_rdata", 72'(p0_rdata), 72'(e.rdata));
        if (e.dok1) check("p1_rdata", 72'(p1_rdata), 72'(e.rdata));
        if (e.chk_fields)
          check("dcache_fields",
                {dcache_wr, dcache_size, dcache_wstrb, dcache_addr, dcache_wdata, dcache_uncached},
                e.fields);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    p0_req = 0; p0_wr = 0; p0_size = 0; p0_wstrb = 0; p0_addr = 0; p0_wdata = 0; p0_uncached = 0;
    p1_req = 0; p1_wr = 0; p1_size = 0; p1_wstrb = 0; p1_addr = 0; p1_wdata = 0; p1_uncached = 0;
    dcache_addr_ok = 0; dcache_data_ok = 0; dcache_rdata = 0;
    repeat (2) @(posedge clk);

    step(0, 0, 0, 0, 0, 0);

    // Both ports every cycle: p1 wins every fourth cycle.
    for (int i = 0; i < 8; i++) step(1, 1, 1, 1, i > 0, $urandom);
    step(1, 0, 0, 0, 1, $urandom);

    // Stalled handshake keeps p0 granted while p1 waits.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, $urandom);
    step(1, 0, 0, 0, 1, $urandom);

    // Fill to MAX_OUTSTANDING, try a fifth, then drain in order.
    step(1, 1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 32'h11);
    step(1, 0, 0, 0, 1, 32'h22);
    step(1, 0, 0, 0, 1, 32'h33);
    step(1, 0, 0, 0, 1, 32'h44);

    // Response with nothing outstanding.
    step(1, 0, 0, 0, 1, 32'hdead);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Reset with three outstanding and the lock held.
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 32'h55);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom);
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 72'(exp_q.size()), 72'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
